serv_timer_wb: RTL and testbench

- Wishbone-style data-bus responder. Answers the single-outstanding cyc/ack requests issued by the SERV core's data bus.
- Holds a RISC-V style 64-bit mtime counter, a 64-bit mtimecmp register and a prescaler.
- Drives the core's timer interrupt input.
- Sits beside the RF-backed SERV core, decoded from the dbus address space by the system interconnect.

---
 rtl/serv_timer_wb.sv | 140 ++++++++++++++
 tb/tb_serv_timer_wb.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serv_timer_wb.sv
// serv_timer_wb: Wishbone-style responder holding a 64-bit mtime counter, mtimecmp and prescaler for SERV.
// Build option SERV_TIMER_SNAPSHOT_EN: mtime[31:0] reads latch mtime[63:32] into a shadow returned at index 1.
module serv_timer_wb #(
  parameter int PRESCALE_W = 16,
  parameter int RESET_DIV  = 0
) (
  input  logic        clk,
  input  logic        i_rst,
  input  logic [4:0]  i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic        o_timer_irq
);

  localparam logic [2:0] REG_MTIME_LO = 3'd0;
  localparam logic [2:0] REG_MTIME_HI = 3'd1;
  localparam logic [2:0] REG_CMP_LO   = 3'd2;
  localparam logic [2:0] REG_CMP_HI   = 3'd3;
  localparam logic [2:0] REG_CTRL     = 3'd4;

  logic [63:0]           mtime;
  logic [63:0]           mtimecmp;
  logic [63:0]           mtime_nxt;
  logic [PRESCALE_W-1:0] div;
  logic [PRESCALE_W-1:0] cnt;
  logic                  irq_en;

  logic [2:0]  idx;
  logic        req;
  logic        wr;
  logic        rd;
  logic        tick;
  logic [31:0] ctrl_word;
  logic [31:0] ctrl_wr;
  logic [31:0] mtime_hi_rd;
  logic [31:0] rd_word;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  // A request is a cyc seen while not already acking; sel=0 writes ack but touch nothing.
  assign idx  = i_wb_adr[4:2];
  assign req  = i_wb_cyc & ~o_wb_ack;
  assign wr   = req & i_wb_we & (|i_wb_sel);
  assign rd   = req & ~i_wb_we;
  assign tick = (cnt == div);

  // NOTE: every always_comb output gets a default before any conditional update, so no latch is inferred.
  always_comb begin
    ctrl_word                 = '0;
    ctrl_word[PRESCALE_W-1:0] = div;
    ctrl_word[31]             = irq_en;
  end

  assign ctrl_wr = merge_bytes(ctrl_word, i_wb_dat, i_wb_sel);

`ifdef SERV_TIMER_SNAPSHOT_EN
  logic [31:0] mtime_hi_shadow;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      mtime_hi_shadow <= '0;
    end else if (rd && idx == REG_MTIME_LO) begin
      mtime_hi_shadow <= mtime[63:32];
    end
  end

  assign mtime_hi_rd = mtime_hi_shadow;
`else
  assign mtime_hi_rd = mtime[63:32];
`endif

  always_comb begin
    rd_word = '0;
    case (idx)
      REG_MTIME_LO: rd_word = mtime[31:0];
      REG_MTIME_HI: rd_word = mtime_hi_rd;
      REG_CMP_LO:   rd_word = mtimecmp[31:0];
      REG_CMP_HI:   rd_word = mtimecmp[63:32];
      REG_CTRL:     rd_word = ctrl_word;
      default:      rd_word = '0;
    endcase
  end

  // A software write to either mtime half replaces that cycle's tick; the other half holds.
  always_comb begin
    mtime_nxt = tick ? mtime + 64'd1 : mtime;
    if (wr && idx == REG_MTIME_LO) begin
      mtime_nxt = {mtime[63:32], merge_bytes(mtime[31:0], i_wb_dat, i_wb_sel)};
    end
    if (wr && idx == REG_MTIME_HI) begin
      mtime_nxt = {merge_bytes(mtime[63:32], i_wb_dat, i_wb_sel), mtime[31:0]};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      o_wb_ack    <= 1'b0;
      o_wb_rdt    <= '0;
      o_timer_irq <= 1'b0;
      mtime       <= '0;
      mtimecmp    <= '1;
      div         <= PRESCALE_W'(RESET_DIV);
      cnt         <= '0;
      irq_en      <= 1'b0;
    end else begin
      o_wb_ack    <= req;
      o_wb_rdt    <= rd ? rd_word : '0;
      o_timer_irq <= irq_en & (mtime >= mtimecmp);
      mtime       <= mtime_nxt;
      cnt         <= tick ? '0 : cnt + PRESCALE_W'(1);
      if (wr) begin
        case (idx)
          REG_CMP_LO: mtimecmp[31:0]  <= merge_bytes(mtimecmp[31:0], i_wb_dat, i_wb_sel);
          REG_CMP_HI: mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], i_wb_dat, i_wb_sel);
          REG_CTRL: begin
            div    <= ctrl_wr[PRESCALE_W-1:0];
            irq_en <= ctrl_wr[31];
            cnt    <= '0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serv_timer_wb.sv
// tb_serv_timer_wb: directed plus randomized bus traffic against a behavioural timer model,
// with every-cycle comparison of ack, rdt and irq.
`timescale 1ns/1ps
module tb_serv_timer_wb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  wb_adr = '0;
  logic [31:0] wb_dat = '0;
  logic [3:0]  wb_sel = '0;
  logic        wb_we  = 1'b0;
  logic        wb_cyc = 1'b0;
  logic [31:0] wb_rdt;
  logic        wb_ack;
  logic        timer_irq;

  always #5 clk = ~clk;

  serv_timer_wb #(.PRESCALE_W(16), .RESET_DIV(0)) dut (
    .clk        (clk),
    .i_rst      (rst),
    .i_wb_adr   (wb_adr),
    .i_wb_dat   (wb_dat),
    .i_wb_sel   (wb_sel),
    .i_wb_we    (wb_we),
    .i_wb_cyc   (wb_cyc),
    .o_wb_rdt   (wb_rdt),
    .o_wb_ack   (wb_ack),
    .o_timer_irq(timer_irq)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: the timer as plain registers plus a divider phase.
  logic [63:0] m_time, m_cmp, m_new_time;
  logic [15:0] m_div, m_cnt, m_new_cnt;
  logic        m_en, m_ack, m_irq, m_req, m_tick, m_new_irq;
  logic [31:0] m_rdt, m_new_rdt, m_shadow, m_ctrl;
  logic [2:0]  m_idx;
  bit          m_valid = 1'b0;

  function automatic logic [31:0] apply_sel(input logic [31:0] old_val, input logic [31:0] dat,
                                            input logic [3:0] sel);
    logic [31:0] mask;
    mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    return (old_val & ~mask) | (dat & mask);
  endfunction

  function automatic logic [31:0] reg_value(input logic [2:0] idx);
    case (idx)
      3'd0: return m_time[31:0];
`ifdef SERV_TIMER_SNAPSHOT_EN
      3'd1: return m_shadow;
`else
      3'd1: return m_time[63:32];
`endif
      3'd2: return m_cmp[31:0];
      3'd3: return m_cmp[63:32];
      3'd4: return {m_en, 15'b0, m_div};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_time = '0; m_cmp = '1; m_div = '0; m_cnt = '0; m_en = 1'b0;
      m_ack = 1'b0; m_rdt = '0; m_irq = 1'b0; m_shadow = '0;
      m_valid = 1'b1;
    end else begin
      m_idx      = wb_adr[4:2];
      m_req      = wb_cyc && !m_ack;
      m_tick     = (m_cnt == m_div);
      m_new_time = m_time + (m_tick ? 64'd1 : 64'd0);
      m_new_cnt  = m_tick ? 16'd0 : m_cnt + 16'd1;
      m_new_irq  = m_en && (m_time >= m_cmp);
      m_new_rdt  = '0;
      if (m_req && !wb_we) begin
        m_new_rdt = reg_value(m_idx);
        if (m_idx == 3'd0) m_shadow = m_time[63:32];
      end
      if (m_req && wb_we && wb_sel != 4'h0) begin
        case (m_idx)
          3'd0: m_new_time = {m_time[63:32], apply_sel(m_time[31:0], wb_dat, wb_sel)};
          3'd1: m_new_time = {apply_sel(m_time[63:32], wb_dat, wb_sel), m_time[31:0]};
          3'd2: m_cmp[31:0] = apply_sel(m_cmp[31:0], wb_dat, wb_sel);
          3'd3: m_cmp[63:32] = apply_sel(m_cmp[63:32], wb_dat, wb_sel);
          3'd4: begin
            m_ctrl    = apply_sel({m_en, 15'b0, m_div}, wb_dat, wb_sel);
            m_div     = m_ctrl[15:0];
            m_en      = m_ctrl[31];
            m_new_cnt = 16'd0;
          end
          default: ;
        endcase
      end
      m_time = m_new_time;
      m_cnt  = m_new_cnt;
      m_ack  = m_req;
      m_rdt  = m_new_rdt;
      m_irq  = m_new_irq;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("ack", wb_ack, m_ack);
      check("rdt", wb_rdt, m_rdt);
      check("irq", timer_irq, m_irq);
    end
  end

  // One transaction: request, ack cycle (data captured), then one idle cycle.
  task automatic bus(input logic we, input logic [2:0] idx, input logic [31:0] dat,
                     input logic [3:0] sel, output logic [31:0] rdata);
    wb_cyc = 1'b1;
    wb_we  = we;
    wb_adr = {idx, 2'($urandom_range(0, 3))};
    wb_dat = dat;
    wb_sel = sel;
    @(posedge clk); #1;
    check("bus_ack", wb_ack, 1'b1);
    rdata  = wb_rdt;
    wb_cyc = 1'b0;
    wb_we  = 1'b0;
    @(posedge clk); #1;
  endtask

  logic [31:0] rv, v1, r_dat;
  logic [2:0]  r_idx;
  logic [3:0]  r_sel;
  logic        r_we;
  int unsigned r_pick;

  initial begin
    // Reset, then 10 idle cycles; the first lo read sees exactly 10 ticks.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("idle_ack", wb_ack, 1'b0);
    check("idle_rdt", wb_rdt, 32'h0);
    check("idle_irq", timer_irq, 1'b0);
    wb_cyc = 1'b1; wb_we = 1'b0; wb_adr = 5'd0; wb_sel = 4'hF;
    @(posedge clk); #1;
    check("first_ack", wb_ack, 1'b1);
    check("first_lo", wb_rdt, 32'd10);
    check("model_first_lo", m_rdt, 32'd10);
    wb_cyc = 1'b0;
    @(posedge clk); #1;
    check("ack_one_cycle", wb_ack, 1'b0);

    // Divide by 4: 40 cycles between reads gives exactly 10 ticks.
    bus(1'b1, 3'd4, 32'h8000_0003, 4'hF, rv);
    bus(1'b0, 3'd4, 32'h0, 4'hF, rv);
    check("ctrl_read", rv, 32'h8000_0003);
    bus(1'b0, 3'd0, 32'h0, 4'hF, v1);
    repeat (38) @(posedge clk);
    #1;
    bus(1'b0, 3'd0, 32'h0, 4'hF, rv);
    check("div4_delta", rv - v1, 32'd10);

    // 64-bit wrap with div=0.
    bus(1'b1, 3'd4, 32'h0, 4'hF, rv);
    bus(1'b1, 3'd1, 32'hFFFF_FFFF, 4'hF, rv);
    bus(1'b1, 3'd0, 32'hFFFF_FFFF, 4'hF, rv);
    bus(1'b0, 3'd0, 32'h0, 4'hF, rv);
    check("wrap_lo", rv, 32'h0);
    bus(1'b0, 3'd1, 32'h0, 4'hF, rv);
    check("wrap_hi", rv, 32'h0);

    // Interrupt at mtime == 50, cleared by raising mtimecmp.
    bus(1'b1, 3'd4, 32'h8000_0000, 4'hF, rv);
    bus(1'b1, 3'd2, 32'd50, 4'hF, rv);
    bus(1'b1, 3'd3, 32'd0, 4'hF, rv);
    bus(1'b1, 3'd0, 32'd0, 4'hF, rv);
    repeat (49) @(posedge clk);
    #1;
    check("irq_before_50", timer_irq, 1'b0);
    @(posedge clk); #1;
    check("irq_at_50", timer_irq, 1'b1);
    wb_cyc = 1'b1; wb_we = 1'b1; wb_adr = {3'd3, 2'b00}; wb_dat = 32'd1; wb_sel = 4'hF;
    @(posedge clk); #1;
    check("cmphi_ack", wb_ack, 1'b1);
    check("irq_held_at_ack", timer_irq, 1'b1);
    wb_cyc = 1'b0; wb_we = 1'b0;
    @(posedge clk); #1;
    check("irq_fall", timer_irq, 1'b0);

    // Byte enables and unmapped space, from reset state.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus(1'b1, 3'd2, 32'hAABB_CCDD, 4'b0010, rv);
    bus(1'b0, 3'd2, 32'h0, 4'hF, rv);
    check("sel_merge", rv, 32'hFFFF_CCFF);
    bus(1'b1, 3'd2, 32'h0, 4'b0000, rv);
    bus(1'b0, 3'd2, 32'h0, 4'hF, rv);
    check("sel_zero", rv, 32'hFFFF_CCFF);
    bus(1'b1, 3'd6, 32'h1234_5678, 4'hF, rv);
    bus(1'b0, 3'd6, 32'h0, 4'hF, rv);
    check("unmapped", rv, 32'h0);

    // Tear-free high read across a low-word carry.
    bus(1'b1, 3'd1, 32'h0, 4'hF, rv);
    bus(1'b1, 3'd0, 32'hFFFF_FFF0, 4'hF, rv);
    bus(1'b0, 3'd0, 32'h0, 4'hF, rv);
    check("snap_lo", rv, 32'hFFFF_FFF1);
    repeat (30) @(posedge clk);
    #1;
    bus(1'b0, 3'd1, 32'h0, 4'hF, rv);
`ifdef SERV_TIMER_SNAPSHOT_EN
    check("snap_hi", rv, 32'd0);
`else
    check("snap_hi", rv, 32'd1);
`endif

    // Reset while a request is pending: the ack is lost.
    wb_cyc = 1'b1; wb_we = 1'b0; wb_adr = 5'd0; rst = 1'b1;
    @(posedge clk); #1;
    check("rst_kills_ack", wb_ack, 1'b0);
    wb_cyc = 1'b0; rst = 1'b0;
    @(posedge clk); #1;

    // Randomized traffic; the every-cycle compare does the checking.
    for (int k = 0; k < 400; k++) begin
      r_pick = $urandom_range(0, 99);
      if (r_pick < 2) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
      end else if (r_pick < 4) begin
        wb_cyc = 1'b1; wb_we = 1'($urandom); wb_adr = 5'($urandom); rst = 1'b1;
        @(posedge clk); #1;
        wb_cyc = 1'b0; wb_we = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
      end else if (r_pick < 18) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end else begin
        r_idx = 3'($urandom_range(0, 7));
        r_we  = 1'($urandom);
        r_sel = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
        r_dat = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 300);
        if (r_idx == 3'd4) r_dat = {1'($urandom), 15'($urandom), 16'($urandom_range(0, 3))};
        bus(r_we, r_idx, r_dat, r_sel, rv);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
